ram_access_sequencer: RTL and testbench
=======================================

// Module: ram_access_sequencer
// PURPOSE
//  Downstream stage of the memory-control path. Accepts one RAM request (address, write data, r/w flag)
//  per handshake and drives a fixed-wait-state synchronous RAM. Returns read data (or a write ack) on a
//  held response handshake. The read data feeds the memory-control ram_data_in / LDR path.
// PARAMETERS
//  ADDR_W       16     request/RAM address width
//  DATA_W       32     data width
//  WAIT_CYCLES  2      extra RAM cycles after the first enable cycle before mem_rdata is valid (0 allowed)
//  MEM_DEPTH    65536  number of valid words; addresses >= MEM_DEPTH return an error with no RAM access
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       sequencer can accept (IDLE only)
//  req_rw     in   1       1 = write, 0 = read (same encoding as ram_rw_flag)
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       response present; held until rsp_ready
//  rsp_ready  in   1       consumer accepts response
//  rsp_rdata  out  DATA_W  read data; 0 for writes and errors
//  rsp_err    out  1       address out of range
//  mem_en     out  1       RAM enable
//  mem_we     out  1       RAM write enable (only with mem_en)
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data, valid on the last ACCESS cycle
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE. Counter 0. All outputs 0, except req_ready=1 once rst deasserts.
//    A reset mid-ACCESS or mid-RESP aborts the transaction. mem_en/mem_we drop immediately.
//    The pending response is lost.
//  - FSM: IDLE -> ACCESS | RESP ; ACCESS -> RESP ; RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid at edge T, latch rw/addr/wdata.
//     - If addr < MEM_DEPTH, go to ACCESS with counter=WAIT_CYCLES.
//     - Otherwise go to RESP with rsp_err=1 and rsp_rdata=0. No mem_en pulse.
//  - ACCESS: mem_en=1, mem_we=latched rw, mem_addr/mem_wdata=latched values, all stable for the whole state.
//    The counter decrements each cycle. In the cycle with counter==0:
//     - reads capture mem_rdata into rsp_rdata;
//     - writes load 0;
//     - go to RESP.
//    ACCESS lasts exactly WAIT_CYCLES+1 cycles.
//  - RESP: rsp_valid=1 and data/err held stable. req_ready=0. On rsp_ready, go to IDLE.
//    rsp_valid and rsp_err clear at that edge.
//  - Latency: accept edge T -> rsp_valid high from edge T+WAIT_CYCLES+2 for in-range requests,
//    and from edge T+1 for errors.
//  - Throughput: no new request is accepted in the same cycle a response completes.
//    Back-to-back issue rate is one per WAIT_CYCLES+3 cycles.
//  - Outside ACCESS: mem_en=mem_we=0. mem_addr/mem_wdata hold their last value.
//  - req_valid while req_ready=0 is ignored. The requester holds it.
//  - Counter width = max(1,$clog2(WAIT_CYCLES+1)). It never wraps: it is loaded only on entry to ACCESS.
//  - MEM_DEPTH == 2**ADDR_W: range check is constant-true and no error is ever produced.
// STRUCTURE
//  - Package mem_ctrl_pkg: state enum {IDLE, ACCESS, RESP}; RW_READ=0 / RW_WRITE=1 constants; ADDR_W/DATA_W defaults.
//  - Sub-module wait_counter: load/decrement/zero-flag down counter, parameterised on WAIT_CYCLES.
//    Everything else stays in the top.
// TESTING
//  1. Reset: pulse rst mid-ACCESS -> same cycle mem_en=0, rsp_valid=0. After release, req_ready=1 and state is IDLE.
//  2. Read, WAIT_CYCLES=2: req addr=0x0010, RAM returns 0xDEADBEEF.
//     -> mem_en high exactly 3 cycles, rsp_valid at T+4, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3. Write: addr=0x00FF, wdata=0x12345678.
//     -> mem_we=1 for 3 cycles with stable addr/data, then rsp_valid with rsp_rdata=0.
//  4. Out of range, MEM_DEPTH=256: addr=0x0100.
//     -> no mem_en, rsp_valid at T+1, rsp_err=1. Addr=0x00FF is accepted normally.
//  5. Backpressure: hold rsp_ready=0 for 5 cycles.
//     -> rsp_valid/rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until after rsp_ready.
//  6. WAIT_CYCLES=0 build: back-to-back reads.
//     -> mem_en pulses 1 cycle each, rsp_valid at T+2, accept rate is one per 3 cycles.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-control path.
// The RAM sequencer and its wait counter both import this package.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 32;

    // A WAIT_CYCLES of 0 still needs a 1-bit counter.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Down counter for RAM wait states.
// It is loaded with WAIT_CYCLES, decrements to zero and then holds there.
module wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int CW = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ram_access_sequencer.sv
// Sequences one request at a time onto a fixed-wait-state synchronous RAM.
// Each request returns one held response: read data, a write ack or a range error.
module ram_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int     ADDR_W      = ADDR_W_DEFAULT,
    parameter int     DATA_W      = DATA_W_DEFAULT,
    parameter int     WAIT_CYCLES = 2,
    parameter longint MEM_DEPTH   = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic in_range;
    logic cnt_load;
    logic cnt_zero;

    // When the RAM fills the whole address space the check collapses to a constant.
    generate
        if (MEM_DEPTH >= (64'd1 << ADDR_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);
            assign in_range = (req_addr < DEPTH_LIM);
        end
    endgenerate

    assign cnt_load = (state_q == IDLE) && req_valid && in_range;

    wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .load_i(cnt_load),
        .dec_i (state_q == ACCESS),
        .zero_o(cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (in_range) begin
                            state_q     <= ACCESS;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_rw;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // mem_rdata is only valid in the last enable cycle.
                    if (cnt_zero) begin
                        state_q     <= RESP;
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= (mem_we_q == RW_READ) ? mem_rdata : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer: instance 0 has WAIT_CYCLES=2 and MEM_DEPTH=256, instance 1 has WAIT_CYCLES=0 and full depth.
// A timeline model checks every cycle, and directed transactions pin latencies and data.
module tb_ram_access_sequencer;

    localparam int     AW      = 16;
    localparam int     DW      = 32;
    localparam int     W_A     = 2;
    localparam int     W_B     = 0;
    localparam longint DEPTH_A = 256;
    localparam longint DEPTH_B = 65536;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready, req_rw, rsp_valid, rsp_ready, rsp_err, mem_en, mem_we;
    logic [AW-1:0] req_addr [2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] req_wdata[2];
    logic [DW-1:0] rsp_rdata[2];
    logic [DW-1:0] mem_wdata[2];
    logic [DW-1:0] mem_rdata[2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W_A), .MEM_DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    ram_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W_B), .MEM_DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    function automatic int wv(input int d);
        return (d == 0) ? W_A : W_B;
    endfunction

    function automatic longint depth(input int d);
        return (d == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
    endfunction

    // ---------------- RAM device: data valid only in the last enable cycle ----------------
    int          en_cnt [2];
    logic [31:0] dev_ram[256];
    bit          dev_wr [256];

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) en_cnt[d] <= 0;
            else     en_cnt[d] <= mem_en[d] ? en_cnt[d] + 1 : 0;
        end
        if (!rst && mem_en[0] && mem_we[0]) begin
            dev_ram[mem_addr[0][7:0]] <= mem_wdata[0];
            dev_wr[mem_addr[0][7:0]]  <= 1'b1;
        end
    end

    assign mem_rdata[0] = (mem_en[0] && en_cnt[0] == W_A)
        ? (dev_wr[mem_addr[0][7:0]] ? dev_ram[mem_addr[0][7:0]] : init_word(mem_addr[0]))
        : (32'hBAD0_0000 | {16'h0, mem_addr[0]});
    assign mem_rdata[1] = (mem_en[1] && en_cnt[1] == W_B)
        ? init_word(mem_addr[1]) : (32'hBAD1_0000 | {16'h0, mem_addr[1]});

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // m_k counts the samples since acceptance: mem_en is expected at samples 1..W+1,
    // and an in-range response from sample W+2 onward; an error response from sample 1.
    bit          m_active[2];
    bit          m_inr   [2];
    bit          m_rw    [2];
    int          m_k     [2];
    logic [15:0] m_last_addr [2];
    logic [31:0] m_last_wdata[2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_ram   [256];
    bit          m_wr    [256];
    logic        e_valid, e_en;

    function automatic logic [31:0] model_read(input int d, input logic [15:0] a);
        if (d == 0 && m_wr[a[7:0]]) return m_ram[a[7:0]];
        return init_word(a);
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk1($sformatf("%0d.rst_req_ready", d), req_ready[d], 1'b0);
                chk1($sformatf("%0d.rst_rsp_valid", d), rsp_valid[d], 1'b0);
                chk1($sformatf("%0d.rst_rsp_err", d), rsp_err[d], 1'b0);
                chk1($sformatf("%0d.rst_mem_en", d), mem_en[d], 1'b0);
                chk1($sformatf("%0d.rst_mem_we", d), mem_we[d], 1'b0);
                chkw($sformatf("%0d.rst_mem_addr", d), 32'(mem_addr[d]), 32'h0);
                m_active[d]     = 1'b0;
                m_last_addr[d]  = '0;
                m_last_wdata[d] = '0;
            end else begin
                e_valid = m_active[d] && (m_inr[d] ? (m_k[d] >= wv(d) + 2) : (m_k[d] >= 1));
                e_en    = m_active[d] && m_inr[d] && (m_k[d] >= 1) && (m_k[d] <= wv(d) + 1);
                chk1($sformatf("%0d.req_ready", d), req_ready[d], !m_active[d]);
                chk1($sformatf("%0d.rsp_valid", d), rsp_valid[d], e_valid);
                chk1($sformatf("%0d.rsp_err", d), rsp_err[d], e_valid && !m_inr[d]);
                chk1($sformatf("%0d.mem_en", d), mem_en[d], e_en);
                chk1($sformatf("%0d.mem_we", d), mem_we[d], e_en && m_rw[d]);
                chkw($sformatf("%0d.mem_addr", d), 32'(mem_addr[d]), 32'(m_last_addr[d]));
                chkw($sformatf("%0d.mem_wdata", d), mem_wdata[d], m_last_wdata[d]);
                if (e_valid) chkw($sformatf("%0d.rsp_rdata", d), rsp_rdata[d], m_rdata[d]);
                if (!m_active[d]) begin
                    if (req_valid[d]) begin
                        m_active[d] = 1'b1;
                        m_k[d]      = 1;
                        m_rw[d]     = req_rw[d];
                        m_inr[d]    = longint'(req_addr[d]) < depth(d);
                        if (m_inr[d]) begin
                            m_last_addr[d]  = req_addr[d];
                            m_last_wdata[d] = req_wdata[d];
                        end
                        m_rdata[d] = (m_inr[d] && !req_rw[d]) ? model_read(d, req_addr[d]) : 32'h0;
                        if (m_inr[d] && req_rw[d] && d == 0) begin
                            m_ram[req_addr[d][7:0]] = req_wdata[d];
                            m_wr[req_addr[d][7:0]]  = 1'b1;
                        end
                    end
                end else if (e_valid && rsp_ready[d]) begin
                    m_active[d] = 1'b0;
                end else begin
                    m_k[d]++;
                end
            end
        end
    end

    // ---------------- stimulus tasks (called just after a rising edge) ----------------
    task automatic wait_accept(input int d, output int t_acc);
        bit got = 1'b0;
        t_acc = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                got   = 1'b1;
                t_acc = cyc + 1;
            end
        end
        chk1($sformatf("%0d.accept_timeout", d), got, 1'b1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic issue(input int d, input logic rw, input logic [15:0] a,
                         input logic [31:0] wd, output int t_acc);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b1;
        req_rw[d]    = rw;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        wait_accept(d, t_acc);
    endtask

    task automatic wait_rsp(input int d, output int t_rsp, output int n_en, output int n_we,
                            output logic [31:0] rd, output logic er);
        bit got = 1'b0;
        t_rsp = -1; n_en = 0; n_we = 0; rd = 'x; er = 1'bx;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (mem_en[d]) n_en++;
            if (mem_we[d]) n_we++;
            if (rsp_valid[d]) begin
                got   = 1'b1;
                t_rsp = cyc + 1;
                rd    = rsp_rdata[d];
                er    = rsp_err[d];
            end
        end
        chk1($sformatf("%0d.rsp_timeout", d), got, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before t=100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, t2, t3, tr, ne, nw, e;
        logic [31:0] rd, rd0;
        logic er;

        rst = 1'b1;
        req_valid = '0; req_rw = '0; rsp_ready = 2'b11;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = '0; req_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("release_ready_a", req_ready[0], 1'b1);
        chk1("release_ready_b", req_ready[1], 1'b1);

        // Read with two wait states
        issue(0, 1'b0, 16'h0010, 32'h0, t0);
        wait_rsp(0, tr, ne, nw, rd, er);
        $display("read  a=0010 latency=%0d en=%0d rdata=%h err=%b", tr - t0, ne, rd, er);
        chkw("rd_latency", 32'(tr - t0), 32'd4);
        chkw("rd_en_cycles", 32'(ne), 32'd3);
        chkw("rd_data", rd, 32'hDEADBEEF);
        chk1("rd_err", er, 1'b0);

        // Write, then read it back
        issue(0, 1'b1, 16'h00FF, 32'h12345678, t0);
        wait_rsp(0, tr, ne, nw, rd, er);
        $display("write a=00FF latency=%0d en=%0d we=%0d rdata=%h", tr - t0, ne, nw, rd);
        chkw("wr_latency", 32'(tr - t0), 32'd4);
        chkw("wr_we_cycles", 32'(nw), 32'd3);
        chkw("wr_rdata", rd, 32'h0);
        issue(0, 1'b0, 16'h00FF, 32'h0, t0);
        wait_rsp(0, tr, ne, nw, rd, er);
        $display("read  a=00FF rdata=%h", rd);
        chkw("wr_readback", rd, 32'h12345678);

        // Out-of-range address
        issue(0, 1'b0, 16'h0100, 32'h0, t0);
        wait_rsp(0, tr, ne, nw, rd, er);
        $display("read  a=0100 latency=%0d en=%0d err=%b rdata=%h", tr - t0, ne, er, rd);
        chkw("oor_latency", 32'(tr - t0), 32'd1);
        chkw("oor_en_cycles", 32'(ne), 32'd0);
        chk1("oor_err", er, 1'b1);
        chkw("oor_rdata", rd, 32'h0);

        // Backpressure with a second request held
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 16'h0020, 32'h0, t0);
        wait_rsp(0, tr, ne, nw, rd0, er);
        chkw("bp_first_data", rd0, 32'hFFDF0020);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 16'h0030;
        repeat (5) begin
            @(negedge clk);
            chk1("bp_valid_held", rsp_valid[0], 1'b1);
            chkw("bp_data_held", rsp_rdata[0], 32'hFFDF0020);
            chk1("bp_ready_low", req_ready[0], 1'b0);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        e = cyc;
        wait_accept(0, t2);
        $display("backpressure release edge=%0d second accept edge=%0d", e, t2);
        chkw("bp_accept_after", 32'(t2 - e), 32'd2);
        wait_rsp(0, tr, ne, nw, rd, er);
        chkw("bp_second_data", rd, 32'hFFCF0030);

        // Reset in the middle of an access
        issue(0, 1'b0, 16'h0040, 32'h0, t0);
        @(negedge clk);
        chk1("mid_access_en", mem_en[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        $display("reset mid-access: mem_en=%b rsp_valid=%b", mem_en[0], rsp_valid[0]);
        chk1("rst_en_drop", mem_en[0], 1'b0);
        chk1("rst_valid_drop", rsp_valid[0], 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_ready", req_ready[0], 1'b1);

        // Zero wait states: single read then back-to-back reads
        issue(1, 1'b0, 16'h1234, 32'h0, t0);
        wait_rsp(1, tr, ne, nw, rd, er);
        $display("read  b a=1234 latency=%0d en=%0d rdata=%h", tr - t0, ne, rd);
        chkw("w0_latency", 32'(tr - t0), 32'd2);
        chkw("w0_en_cycles", 32'(ne), 32'd1);
        chkw("w0_data", rd, 32'hEDCB1234);
        issue(1, 1'b0, 16'h0001, 32'h0, t1);
        issue(1, 1'b0, 16'hFFFF, 32'h0, t2);
        issue(1, 1'b0, 16'h8000, 32'h0, t3);
        wait_rsp(1, tr, ne, nw, rd, er);
        $display("b2b   b accepts=%0d,%0d,%0d last rdata=%h err=%b", t1, t2, t3, rd, er);
        chkw("b2b_gap1", 32'(t2 - t1), 32'd3);
        chkw("b2b_gap2", 32'(t3 - t2), 32'd3);
        chkw("b2b_data", rd, 32'h7FFF8000);
        chk1("b2b_err", er, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
